serializer_frame_scheduler: RTL

//  Shares one 8-bit serializer among N byte requesters. Divides time into 8-clock frames, one byte per frame.
//  At each frame boundary, picks one requester by round-robin and loads its byte, or loads an idle filler byte.

---
 rtl/serdes_pkg.sv | 24 ++
 rtl/serializer_frame_scheduler_if.sv | 32 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/serializer_frame_scheduler.sv | 90 +++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer front end: frame geometry, default
// filler byte, scheduler state encoding and width helpers.
package serdes_pkg;
  localparam int         FRAME_BITS    = 8;
  localparam int         SLOT_W        = 3;      // bits of bit_slot, covers FRAME_BITS
  localparam logic [7:0] IDLE_CHAR_DEF = 8'hBC;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Requester index width; never zero so a single requester still has a port.
  function automatic int src_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serializer_frame_scheduler_if.sv
// Requester / serializer bus of the frame scheduler.
//   req_valid, req_data : requester i offers byte req_data[i]
//   req_ready           : byte i accepted at this edge
//   ser_data/load/valid/src, bit_slot, sync_done : serializer-side outputs
// master = requester side (bench or upstream), slave = scheduler.
interface serializer_frame_scheduler_if
  import serdes_pkg::*;
#(
  parameter int N_REQ = 4
) ();
  localparam int SRC_W = src_w(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic [7:0]            ser_data;
  logic                  ser_load;
  logic                  ser_valid;
  logic [SRC_W-1:0]      ser_src;
  logic [SLOT_W-1:0]     bit_slot;
  logic                  sync_done;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_data, ser_load, ser_valid, ser_src, bit_slot, sync_done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_data, ser_load, ser_valid, ser_src, bit_slot, sync_done
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches req starting at ptr, wrapping
// N_REQ-1 -> 0; first set request wins.
//   req     : request vector
//   ptr     : search start index (register kept by the caller)
//   grant   : one-hot grant, all zero when nothing requests
//   gnt_idx : index of the granted request
//   any     : some request was granted
module rr_arbiter
  import serdes_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int SRC_W = src_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             any
);
  logic [SRC_W:0]   sum;
  logic [SRC_W-1:0] idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // One extra bit so ptr+k never overflows before the modulo fold.
      sum = {1'b0, ptr} + (SRC_W + 1)'(k);
      if (sum >= (SRC_W + 1)'(N_REQ)) sum = sum - (SRC_W + 1)'(N_REQ);
      idx = sum[SRC_W-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end
endmodule

// File: rtl/serializer_frame_scheduler.sv
// Shares one 8-bit serializer among N_REQ requesters. Time is cut into
// 8-clock frames; at every frame boundary one byte (a requester's, chosen
// round-robin, or IDLE_CHAR) is loaded. After reset SYNC_FRAMES idle frames
// are sent before any request is served.
//   clk, rst (async, active-low), en (0 freezes everything)
//   bus : requester handshake and serializer outputs (slave modport)
module serializer_frame_scheduler
  import serdes_pkg::*;
#(
  parameter int         N_REQ       = 4,
  parameter int         SYNC_FRAMES = 4,
  parameter logic [7:0] IDLE_CHAR   = IDLE_CHAR_DEF
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         en,
  serializer_frame_scheduler_if.slave bus
);
  localparam int SRC_W = src_w(N_REQ);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q;
  logic [3:0]        sync_q;
  logic [SRC_W-1:0]  ptr_q, gnt_idx, src_q;
  logic [N_REQ-1:0]  grant;
  logic              any, boundary;
  logic [7:0]        data_q;
  logic              valid_q, load_q;

  assign boundary = en && (slot_q == SLOT_W'(FRAME_BITS - 1));

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .grant  (grant),
    .gnt_idx(gnt_idx),
    .any    (any)
  );

  // Ready is only ever offered at the edge that actually takes the byte.
  assign bus.req_ready = (boundary && state_q == RUN) ? grant : '0;

  always_comb begin
    state_d = state_q;
    if (boundary && state_q == SYNC && sync_q == 4'(SYNC_FRAMES - 1)) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SYNC;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q  <= '0;
      sync_q  <= '0;
      ptr_q   <= '0;
      src_q   <= '0;
      data_q  <= IDLE_CHAR;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      // Strobe is a pure function of the previous edge, so it drops while frozen.
      load_q <= boundary;
      if (en) slot_q <= slot_q + SLOT_W'(1);
      if (boundary) begin
        if (state_q == SYNC) begin
          data_q  <= IDLE_CHAR;
          valid_q <= 1'b0;
          sync_q  <= sync_q + 4'd1;
        end else if (any) begin
          data_q  <= bus.req_data[gnt_idx];
          valid_q <= 1'b1;
          src_q   <= gnt_idx;
          ptr_q   <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + SRC_W'(1);
        end else begin
          data_q  <= IDLE_CHAR;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.ser_data  = data_q;
  assign bus.ser_load  = load_q;
  assign bus.ser_valid = valid_q;
  assign bus.ser_src   = src_q;
  assign bus.bit_slot  = slot_q;
  assign bus.sync_done = (state_q == RUN);
endmodule
